// File: rtl/demux_1_n_stream_if.sv
// Stream bundle for the 1-to-N demux: one producer channel in, N consumer channels out.
// slave is the demux side of the bundle, master is the producer/consumer side.
interface demux_1_n_stream_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic [SEL_W-1:0] in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [N_OUT-1:0] out_valid;
    logic [N_OUT-1:0] out_ready;
    logic [CNT_W-1:0] drop_cnt;
    logic             drop_pulse;

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_cnt, drop_pulse
    );

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_cnt, drop_pulse
    );
endinterface

// File: rtl/demux_1_n_stream.sv
// Registered 1-to-N stream demultiplexer with a one-entry output stage.
// Out-of-range selects are dropped and counted in a saturating counter.
//
// state   | meaning
// S_EMPTY | no word held, input always ready
// S_FULL  | word held for one-hot dest r_valid, input ready only if that dest is ready
module demux_1_n_stream #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    demux_1_n_stream_if.slave       bus
);
    typedef enum logic {S_EMPTY, S_FULL} state_t;

    localparam logic [SEL_W:0] LP_N_OUT = (SEL_W+1)'(N_OUT);

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic [N_OUT-1:0] r_valid;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_drop_pulse;

    logic             w_dest_ready;
    logic             w_in_acc;
    logic             w_in_range;
    logic [N_OUT-1:0] w_onehot;

    // r_valid doubles as the one-hot destination register, so no index into out_ready is needed
    assign w_dest_ready = |(r_valid & bus.out_ready);
    assign bus.in_ready = rst_n & ((r_state == S_EMPTY) | w_dest_ready);
    assign w_in_acc     = bus.in_valid & bus.in_ready;
    assign w_in_range   = ({1'b0, bus.in_sel} < LP_N_OUT);
    assign w_onehot     = {{(N_OUT-1){1'b0}}, 1'b1} << bus.in_sel;

    assign bus.out_data   = r_data;
    assign bus.out_valid  = r_valid;
    assign bus.drop_cnt   = r_drop_cnt;
    assign bus.drop_pulse = r_drop_pulse;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_EMPTY;
            r_data       <= '0;
            r_valid      <= '0;
            r_drop_cnt   <= '0;
            r_drop_pulse <= 1'b0;
        end else begin
            r_drop_pulse <= 1'b0;
            case (r_state)
                S_EMPTY: begin
                    if (w_in_acc && w_in_range) begin
                        r_data  <= bus.in_data;
                        r_valid <= w_onehot;
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    // an input accept in FULL implies the held word leaves on this edge
                    if (w_in_acc && w_in_range) begin
                        r_data  <= bus.in_data;
                        r_valid <= w_onehot;
                    end else if (w_dest_ready) begin
                        r_valid <= '0;
                        r_state <= S_EMPTY;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
            if (w_in_acc && !w_in_range) begin
                r_drop_pulse <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_demux_1_n_stream.sv
// Self-checking bench: directed vector table on a 4-channel instance, hand sequences
// for drop/reset/saturation on a 3-channel instance, and a scoreboarded random run.
module tb_demux_1_n_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    demux_1_n_stream_if #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) bus_a ();
    demux_1_n_stream_if #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .CNT_W(8)) bus_b ();

    demux_1_n_stream #(.WIDTH(8), .N_OUT(4), .SEL_W(2), .CNT_W(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    demux_1_n_stream #(.WIDTH(8), .N_OUT(3), .SEL_W(2), .CNT_W(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] rdy;
        logic       e_irdy;
        logic [3:0] e_ov;
        logic [7:0] e_od;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    logic       b_irdy;
    logic [7:0] sb_q [4][$];
    int         sent = 0;
    int         recv = 0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_ov = '0;
    logic [7:0] prev_od = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_b(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [2:0] r);
        bus_b.in_valid  = v;
        bus_b.in_sel    = s;
        bus_b.in_data   = d;
        bus_b.out_ready = r;
        @(negedge clk);
        b_irdy = bus_b.in_ready;
        @(posedge clk);
        #1;
    endtask

    // One random-phase cycle on instance A: score outputs and inputs seen before the edge.
    task automatic sb_cycle();
        logic [3:0] w_acc;
        logic [7:0] exp_d;
        @(negedge clk);
        chk("onehot", 32'($onehot0(bus_a.out_valid)), 32'd1);
        if (prev_stall) begin
            chk("stall_valid", 32'(bus_a.out_valid), 32'(prev_ov));
            chk("stall_data", 32'(bus_a.out_data), 32'(prev_od));
        end
        w_acc = bus_a.out_valid & bus_a.out_ready;
        for (int k = 0; k < 4; k++) begin
            if (w_acc[k]) begin
                if (sb_q[k].size() == 0) begin
                    chk($sformatf("unexpected_ch%0d", k), 32'd1, 32'd0);
                end else begin
                    exp_d = sb_q[k].pop_front();
                    chk($sformatf("order_ch%0d", k), 32'(bus_a.out_data), 32'(exp_d));
                    recv++;
                end
            end
        end
        if (bus_a.in_valid && bus_a.in_ready) begin
            sb_q[bus_a.in_sel].push_back(bus_a.in_data);
            sent++;
        end
        prev_stall = ((bus_a.out_valid & ~bus_a.out_ready) != 4'b0000);
        prev_ov    = bus_a.out_valid;
        prev_od    = bus_a.out_data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int left;
        vecs[0]  = '{1'b1, 2'd2, 8'hA5, 4'b1111, 1'b1, 4'b0100, 8'hA5};
        vecs[1]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00};
        vecs[2]  = '{1'b1, 2'd0, 8'h10, 4'b1111, 1'b1, 4'b0001, 8'h10};
        vecs[3]  = '{1'b1, 2'd1, 8'h11, 4'b1111, 1'b1, 4'b0010, 8'h11};
        vecs[4]  = '{1'b1, 2'd2, 8'h12, 4'b1111, 1'b1, 4'b0100, 8'h12};
        vecs[5]  = '{1'b1, 2'd3, 8'h13, 4'b1111, 1'b1, 4'b1000, 8'h13};
        vecs[6]  = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 8'h00};
        vecs[7]  = '{1'b1, 2'd1, 8'h3C, 4'b1111, 1'b1, 4'b0010, 8'h3C};
        vecs[8]  = '{1'b1, 2'd3, 8'h3D, 4'b1101, 1'b0, 4'b0010, 8'h3C};
        vecs[9]  = '{1'b1, 2'd3, 8'h3D, 4'b0100, 1'b0, 4'b0010, 8'h3C};
        vecs[10] = '{1'b1, 2'd3, 8'h3D, 4'b1001, 1'b0, 4'b0010, 8'h3C};
        vecs[11] = '{1'b1, 2'd3, 8'h3D, 4'b0010, 1'b1, 4'b1000, 8'h3D};
        vecs[12] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b1000, 8'h3D};
        vecs[13] = '{1'b0, 2'd0, 8'h00, 4'b1000, 1'b1, 4'b0000, 8'h00};

        bus_a.in_valid = 1'b0; bus_a.in_sel = '0; bus_a.in_data = '0; bus_a.out_ready = '0;
        bus_b.in_valid = 1'b0; bus_b.in_sel = '0; bus_b.in_data = '0; bus_b.out_ready = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus_a.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus_a.out_data), 32'd0);
        chk("rst_drop_cnt", 32'(bus_a.drop_cnt), 32'd0);
        chk("rst_drop_pulse", 32'(bus_a.drop_pulse), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            bus_a.in_valid  = vecs[i].v;
            bus_a.in_sel    = vecs[i].sel;
            bus_a.in_data   = vecs[i].data;
            bus_a.out_ready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", i), 32'(bus_a.in_ready), 32'(vecs[i].e_irdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(bus_a.out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov != 4'b0000)
                chk($sformatf("v%0d_out_data", i), 32'(bus_a.out_data), 32'(vecs[i].e_od));
            chk($sformatf("v%0d_drop_pulse", i), 32'(bus_a.drop_pulse), 32'd0);
        end
        bus_a.in_valid = 1'b0;

        // Drop path on the 3-channel instance
        step_b(1'b1, 2'd3, 8'hFF, 3'b111);
        chk("drop_in_ready", 32'(b_irdy), 32'd1);
        chk("drop_out_valid", 32'(bus_b.out_valid), 32'd0);
        chk("drop_pulse", 32'(bus_b.drop_pulse), 32'd1);
        chk("drop_cnt1", 32'(bus_b.drop_cnt), 32'd1);
        step_b(1'b0, 2'd0, 8'h00, 3'b111);
        chk("drop_pulse_clr", 32'(bus_b.drop_pulse), 32'd0);
        chk("drop_cnt_hold", 32'(bus_b.drop_cnt), 32'd1);

        // Drop while the held word leaves: stage must empty
        step_b(1'b1, 2'd2, 8'h44, 3'b111);
        chk("b_full_valid", 32'(bus_b.out_valid), 32'b100);
        chk("b_full_data", 32'(bus_b.out_data), 32'h44);
        step_b(1'b1, 2'd3, 8'hEE, 3'b111);
        chk("full_drop_in_ready", 32'(b_irdy), 32'd1);
        chk("full_drop_valid", 32'(bus_b.out_valid), 32'd0);
        chk("full_drop_pulse", 32'(bus_b.drop_pulse), 32'd1);
        chk("drop_cnt2", 32'(bus_b.drop_cnt), 32'd2);
        repeat (3) step_b(1'b1, 2'd3, 8'hFF, 3'b111);
        chk("drop_cnt5", 32'(bus_b.drop_cnt), 32'd5);

        // Reset mid-operation with a stalled held word
        step_b(1'b1, 2'd1, 8'h5A, 3'b000);
        chk("hold_in_ready", 32'(b_irdy), 32'd1);
        chk("hold_valid", 32'(bus_b.out_valid), 32'b010);
        chk("hold_data", 32'(bus_b.out_data), 32'h5A);
        step_b(1'b0, 2'd0, 8'h00, 3'b101);
        chk("hold_stall_in_ready", 32'(b_irdy), 32'd0);
        chk("hold_stall_valid", 32'(bus_b.out_valid), 32'b010);
        chk("hold_stall_data", 32'(bus_b.out_data), 32'h5A);
        rst_n = 1'b0;
        step_b(1'b0, 2'd0, 8'h00, 3'b000);
        chk("mid_rst_in_ready", 32'(b_irdy), 32'd0);
        chk("mid_rst_valid", 32'(bus_b.out_valid), 32'd0);
        chk("mid_rst_data", 32'(bus_b.out_data), 32'd0);
        chk("mid_rst_cnt", 32'(bus_b.drop_cnt), 32'd0);
        chk("mid_rst_pulse", 32'(bus_b.drop_pulse), 32'd0);
        rst_n = 1'b1;
        step_b(1'b1, 2'd0, 8'h77, 3'b000);
        chk("post_rst_in_ready", 32'(b_irdy), 32'd1);
        chk("post_rst_valid", 32'(bus_b.out_valid), 32'b001);
        chk("post_rst_data", 32'(bus_b.out_data), 32'h77);
        step_b(1'b0, 2'd0, 8'h00, 3'b001);
        chk("post_rst_empty", 32'(bus_b.out_valid), 32'd0);

        // Saturation
        repeat (300) step_b(1'b1, 2'd3, 8'hFF, 3'b111);
        chk("sat_cnt", 32'(bus_b.drop_cnt), 32'd255);
        chk("sat_pulse", 32'(bus_b.drop_pulse), 32'd1);
        step_b(1'b0, 2'd0, 8'h00, 3'b111);
        chk("sat_cnt_hold", 32'(bus_b.drop_cnt), 32'd255);
        chk("sat_pulse_clr", 32'(bus_b.drop_pulse), 32'd0);

        // Random traffic on the 4-channel instance
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            bus_a.in_valid  = 1'($urandom_range(0, 1));
            bus_a.in_sel    = 2'($urandom_range(0, 3));
            bus_a.in_data   = 8'(sent);
            bus_a.out_ready = 4'($urandom_range(0, 15));
            sb_cycle();
            cyc++;
        end
        chk("rand_sent", 32'(sent), 32'd1000);
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 4'b1111;
        cyc = 0;
        left = sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size();
        while (left != 0 && cyc < 50) begin
            sb_cycle();
            left = sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size();
            cyc++;
        end
        chk("rand_left", 32'(left), 32'd0);
        chk("rand_recv", 32'(recv), 32'd1000);
        @(negedge clk);
        chk("rand_final_empty", 32'(bus_a.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
